// File: rtl/tx_encoder.sv
// Transmit framer: packs a 1568-bit packet into 26 scrambled 64-bit blocks with CRC10 and tail,
// fills gaps with scrambled IDLE blocks, and offers a raw PRBS31 test pattern.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | emit scrambled IDLE blocks, accept a packet or enter PRBS mode
// ST_SEND | emit data blocks 0..25 of the latched packet
// ST_PRBS | emit 64 raw PRBS31 bits per cycle, scrambler frozen
module tx_encoder #(
    parameter logic [61:0] IDLE_PATTERN = 62'h0,
    parameter logic [3:0]  TAIL_CODE    = 4'hD,
    parameter int unsigned MIN_IDLE     = 1,
    parameter logic [57:0] SCR_SEED     = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic          clk_390p625M,
    input  logic          rst_n,
    input  logic [1567:0] data_1568bit,
    input  logic          data_valid,
    output logic          data_ready,
    input  logic          prbs31_EN,
    output logic [63:0]   data_to_serializer,
    output logic [29:0]   packet_sent_count,
    output logic          prbs31_active
);

    localparam logic [9:0] CRC_POLY   = 10'h233;
    localparam logic [3:0] MIN_IDLE_C = 4'(MIN_IDLE);
    localparam logic [4:0] LAST_BLOCK = 5'd25;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_PRBS} state_t;

    state_t        state;
    logic [1567:0] pkt_sr;
    logic [9:0]    crc;
    logic [4:0]    block_cnt;
    logic [3:0]    idle_cnt;
    logic [57:0]   scr;
    logic [30:0]   lfsr;

    logic [9:0]    crc_blk;
    logic [9:0]    crc_last;
    logic [61:0]   data_payload;
    logic [61:0]   plain;
    logic [57:0]   scr_next;
    logic [61:0]   scr_out;
    logic [30:0]   lfsr_next;
    logic [63:0]   prbs_word;
    logic [3:0]    idle_inc;

    function automatic logic [9:0] crc_fold62(input logic [9:0] c_in, input logic [61:0] d);
        logic [9:0] c;
        logic       fb;
        c = c_in;
        for (int i = 61; i >= 0; i--) begin
            fb = c[9] ^ d[i];
            c  = {c[8:0], 1'b0} ^ ({10{fb}} & CRC_POLY);
        end
        return c;
    endfunction

    function automatic logic [9:0] crc_fold18(input logic [9:0] c_in, input logic [17:0] d);
        logic [9:0] c;
        logic       fb;
        c = c_in;
        for (int i = 17; i >= 0; i--) begin
            fb = c[9] ^ d[i];
            c  = {c[8:0], 1'b0} ^ ({10{fb}} & CRC_POLY);
        end
        return c;
    endfunction

    // Returns {next state, scrambled payload}; the state shifts in scrambled bits.
    function automatic logic [119:0] scramble(input logic [57:0] s_in, input logic [61:0] d);
        logic [57:0] s;
        logic [61:0] o;
        s = s_in;
        o = '0;
        for (int i = 61; i >= 0; i--) begin
            o[i] = d[i] ^ s[38] ^ s[57];
            s    = {s[56:0], o[i]};
        end
        return {s, o};
    endfunction

    function automatic logic [94:0] prbs_step(input logic [30:0] l_in);
        logic [30:0] l;
        logic [63:0] o;
        l = l_in;
        o = '0;
        for (int i = 63; i >= 0; i--) begin
            o[i] = l[30] ^ l[27];
            l    = {l[29:0], o[i]};
        end
        return {l, o};
    endfunction

    always_comb begin
        crc_blk  = crc_fold62(crc, pkt_sr[1567:1506]);
        crc_last = crc_fold18(crc, pkt_sr[1567:1550]);
        if (block_cnt == LAST_BLOCK)
            data_payload = {pkt_sr[1567:1550], 30'h0, crc_last, TAIL_CODE};
        else
            data_payload = pkt_sr[1567:1506];
        plain = (state == ST_SEND) ? data_payload : IDLE_PATTERN;
        {scr_next, scr_out}    = scramble(scr, plain);
        {lfsr_next, prbs_word} = prbs_step(lfsr);
        idle_inc = (idle_cnt == 4'hF) ? idle_cnt : idle_cnt + 4'd1;
    end

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            pkt_sr             <= '0;
            crc                <= '0;
            block_cnt          <= '0;
            idle_cnt           <= MIN_IDLE_C;
            scr                <= SCR_SEED;
            lfsr               <= 31'h7FFF_FFFF;
            data_to_serializer <= '0;
            data_ready         <= 1'b0;
            packet_sent_count  <= '0;
            prbs31_active      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    data_to_serializer <= {2'b10, scr_out};
                    scr                <= scr_next;
                    idle_cnt           <= idle_inc;
                    // PRBS request outranks a pending packet
                    if (prbs31_EN) begin
                        state         <= ST_PRBS;
                        prbs31_active <= 1'b1;
                        data_ready    <= 1'b0;
                    end else if (data_valid && data_ready) begin
                        state      <= ST_SEND;
                        pkt_sr     <= data_1568bit;
                        crc        <= '0;
                        block_cnt  <= '0;
                        data_ready <= 1'b0;
                    end else begin
                        data_ready <= (idle_inc >= MIN_IDLE_C);
                    end
                end
                ST_SEND: begin
                    data_to_serializer <= {2'b01, scr_out};
                    scr                <= scr_next;
                    data_ready         <= 1'b0;
                    if (block_cnt == LAST_BLOCK) begin
                        state             <= ST_IDLE;
                        idle_cnt          <= '0;
                        packet_sent_count <= packet_sent_count + 30'd1;
                    end else begin
                        crc       <= crc_blk;
                        pkt_sr    <= {pkt_sr[1505:0], 62'h0};
                        block_cnt <= block_cnt + 5'd1;
                    end
                end
                ST_PRBS: begin
                    data_ready <= 1'b0;
                    if (prbs31_EN) begin
                        data_to_serializer <= prbs_word;
                        lfsr               <= lfsr_next;
                    end else begin
                        state              <= ST_IDLE;
                        prbs31_active      <= 1'b0;
                        idle_cnt           <= '0;
                        data_to_serializer <= {2'b10, scr_out};
                        scr                <= scr_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_encoder.sv
// Bench for tx_encoder: descrambles the line from a bit history, compares payloads against
// packet slices, a bit-serial CRC10 and a PRBS31 bit-sequence recurrence.
`timescale 1ns/1ps
module tb_tx_encoder;
    localparam int MIN_IDLE = 1;

    logic          clk_390p625M = 1'b0;
    logic          rst_n;
    logic [1567:0] data_1568bit;
    logic          data_valid;
    logic          data_ready;
    logic          prbs31_EN;
    logic [63:0]   data_to_serializer;
    logic [29:0]   packet_sent_count;
    logic          prbs31_active;

    int errors = 0;
    int checks = 0;
    bit line_q[$];
    bit prbs_q[$];
    logic [63:0] obs;

    always #5 clk_390p625M = ~clk_390p625M;

    tx_encoder #(.MIN_IDLE(MIN_IDLE)) dut (
        .clk_390p625M(clk_390p625M),
        .rst_n(rst_n),
        .data_1568bit(data_1568bit),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .prbs31_EN(prbs31_EN),
        .data_to_serializer(data_to_serializer),
        .packet_sent_count(packet_sent_count),
        .prbs31_active(prbs31_active)
    );

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic reset_models();
        line_q.delete();
        repeat (58) line_q.push_back(1'b1);
        prbs_q.delete();
        repeat (31) prbs_q.push_back(1'b1);
    endtask

    // line history: index 0 is the bit 58 positions back, index 19 is 39 back
    task automatic descr(input logic [61:0] p, output logic [61:0] d);
        d = '0;
        for (int i = 61; i >= 0; i--) begin
            d[i] = p[i] ^ line_q[19] ^ line_q[0];
            void'(line_q.pop_front());
            line_q.push_back(p[i]);
        end
    endtask

    task automatic prbs_model(output logic [63:0] w);
        bit b;
        w = '0;
        for (int i = 63; i >= 0; i--) begin
            b = prbs_q[0] ^ prbs_q[3];
            w[i] = b;
            void'(prbs_q.pop_front());
            prbs_q.push_back(b);
        end
    endtask

    function automatic logic [9:0] crc10(input logic [1567:0] p);
        logic [9:0] r;
        logic       top;
        r = '0;
        for (int i = 1567; i >= 0; i--) begin
            top = r[9] ^ p[i];
            r = {r[8:0], 1'b0};
            if (top) r = r ^ 10'h233;
        end
        return r;
    endfunction

    function automatic logic [61:0] exp_block(input logic [1567:0] p, input int k);
        if (k < 25) return p[1567 - 62*k -: 62];
        return {p[17:0], 30'h0, crc10(p), 4'hD};
    endfunction

    function automatic logic [1567:0] rand_pkt();
        logic [1567:0] p;
        for (int i = 0; i < 49; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk_390p625M);
        #1;
        obs = data_to_serializer;
    endtask

    task automatic expect_idle(input string tag);
        logic [61:0] d;
        tick();
        chk({tag, "_hdr"}, 64'(obs[63:62]), 64'(2'b10));
        descr(obs[61:0], d);
        chk({tag, "_idle_pay"}, 64'(d), 64'h0);
    endtask

    task automatic expect_prbs(input string tag);
        logic [63:0] e;
        tick();
        prbs_model(e);
        chk(tag, obs, e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, data_to_serializer, 64'h0);
        chk({tag, "_ready"}, 64'(data_ready), 64'h0);
        chk({tag, "_count"}, 64'(packet_sent_count), 64'h0);
        chk({tag, "_active"}, 64'(prbs31_active), 64'h0);
    endtask

    // Offers pkt, counts IDLE blocks spent waiting for data_ready, then checks all 26 blocks.
    task automatic send_packet(input logic [1567:0] pkt, input string tag, input bit hold,
                               input int prbs_at, input int rst_at, output int waited);
        logic [61:0] d;
        waited = 0;
        data_1568bit = pkt;
        data_valid = 1'b1;
        while (data_ready !== 1'b1 && waited < 40) begin
            expect_idle({tag, "_wait"});
            waited++;
        end
        chk({tag, "_ready_seen"}, 64'(data_ready), 64'h1);
        expect_idle({tag, "_acc"});
        if (!hold) data_valid = 1'b0;
        data_1568bit = ~pkt;
        chk({tag, "_ready_low"}, 64'(data_ready), 64'h0);
        for (int k = 0; k < 26; k++) begin
            tick();
            chk($sformatf("%s_b%0d_hdr", tag, k), 64'(obs[63:62]), 64'(2'b01));
            descr(obs[61:0], d);
            chk($sformatf("%s_b%0d_pay", tag, k), 64'(d), 64'(exp_block(pkt, k)));
            if (k == prbs_at) prbs31_EN = 1'b1;
            if (k == rst_at) begin
                rst_n = 1'b0;
                data_valid = 1'b0;
                #1;
                check_reset_outputs({tag, "_midrst"});
                return;
            end
        end
        chk({tag, "_ready_end"}, 64'(data_ready), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int exp_cnt;
        logic [1567:0] one;
        rst_n = 1'b0;
        data_valid = 1'b0;
        prbs31_EN = 1'b0;
        data_1568bit = '0;
        reset_models();
        repeat (3) @(posedge clk_390p625M);
        #2;
        check_reset_outputs("reset");
        @(negedge clk_390p625M);
        rst_n = 1'b1;

        expect_idle("first_idle");
        chk("first_ready", 64'(data_ready), 64'h1);
        repeat (4) expect_idle("idle_run");

        send_packet('0, "zero_pkt", 1'b0, -1, -1, w);
        chk("zero_count", 64'(packet_sent_count), 64'd1);

        one = '0;
        one[0] = 1'b1;
        send_packet(one, "lsb_pkt", 1'b0, -1, -1, w);
        chk("lsb_count", 64'(packet_sent_count), 64'd2);
        exp_cnt = 2;

        for (int n = 0; n < 100; n++) begin
            send_packet(rand_pkt(), $sformatf("rnd%0d", n), 1'b0, -1, -1, w);
            exp_cnt++;
            chk($sformatf("rnd%0d_count", n), 64'(packet_sent_count), 64'(exp_cnt));
        end

        // data_valid held high: gap between packets is set by MIN_IDLE alone
        send_packet(rand_pkt(), "hold0", 1'b1, -1, -1, w);
        exp_cnt++;
        for (int n = 1; n < 4; n++) begin
            send_packet(rand_pkt(), $sformatf("hold%0d", n), 1'b1, -1, -1, w);
            exp_cnt++;
            chk($sformatf("hold%0d_gap", n), 64'(w), 64'(MIN_IDLE));
            chk($sformatf("hold%0d_count", n), 64'(packet_sent_count), 64'(exp_cnt));
        end
        data_valid = 1'b0;

        // PRBS requested mid-packet: packet completes, one IDLE, then PRBS
        send_packet(rand_pkt(), "prbs_pkt", 1'b0, 10, -1, w);
        exp_cnt++;
        chk("prbs_pkt_count", 64'(packet_sent_count), 64'(exp_cnt));
        expect_idle("prbs_first_idle");
        chk("prbs_active_on", 64'(prbs31_active), 64'h1);
        for (int n = 0; n < 16; n++) begin
            expect_prbs($sformatf("prbs_w%0d", n));
            chk($sformatf("prbs_w%0d_ready", n), 64'(data_ready), 64'h0);
        end
        prbs31_EN = 1'b0;
        expect_idle("prbs_exit");
        chk("prbs_active_off", 64'(prbs31_active), 64'h0);
        chk("prbs_exit_ready", 64'(data_ready), 64'h0);
        repeat (MIN_IDLE) expect_idle("prbs_post");
        chk("prbs_post_ready", 64'(data_ready), 64'h1);

        // data_valid and prbs31_EN together: PRBS wins, LFSR resumes where it stopped
        data_1568bit = rand_pkt();
        data_valid = 1'b1;
        prbs31_EN = 1'b1;
        expect_idle("sim_edge");
        chk("sim_ready", 64'(data_ready), 64'h0);
        expect_prbs("sim_prbs0");
        expect_prbs("sim_prbs1");
        data_valid = 1'b0;
        prbs31_EN = 1'b0;
        expect_idle("sim_exit");
        repeat (MIN_IDLE) expect_idle("sim_post");
        chk("sim_count", 64'(packet_sent_count), 64'(exp_cnt));

        force dut.packet_sent_count = 30'h3FFF_FFFF;
        #1;
        release dut.packet_sent_count;
        send_packet(rand_pkt(), "wrap_pkt", 1'b0, -1, -1, w);
        chk("wrap_count", 64'(packet_sent_count), 64'h0);

        send_packet(rand_pkt(), "rst_pkt", 1'b0, -1, 12, w);
        reset_models();
        @(negedge clk_390p625M);
        rst_n = 1'b1;
        expect_idle("post_rst");
        chk("post_rst_ready", 64'(data_ready), 64'h1);
        repeat (3) expect_idle("post_rst_run");
        chk("post_rst_count", 64'(packet_sent_count), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
